// File: rtl/channel_pb_pkg.sv
// Shared types and sizing for the channel playback block.
package channel_pb_pkg;

    typedef enum logic {IDLE, PLAY} pb_state_t;

    typedef logic [1:0] pair_idx_t;

    localparam int unsigned PAIRS_PER_WORD = 4;
    localparam int unsigned WORD_W         = 2 * PAIRS_PER_WORD;

endpackage

// File: rtl/playback_fifo.sv
// Circular word buffer feeding the playback shift register.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module playback_fifo
    import channel_pb_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [WORD_W-1:0]         wdata,
    input  logic                      pop,
    output logic [WORD_W-1:0]         rdata,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic              wr_en;
    logic              rd_en;

    // Occupancy and status derived from the registered pointers.
    always_comb begin
        cnt   = wptr - rptr;
        full  = (cnt == PW'(DEPTH));
        empty = (wptr == rptr);
        wr_en = push && !full;
        rd_en = pop && !empty;
        rdata = mem[rptr[AW-1:0]];
    end

    // Storage write; contents need no reset since cnt gates visibility.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

    // Pointer advance on accepted push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) wptr <= wptr + PW'(1);
            if (rd_en) rptr <= rptr + PW'(1);
        end
    end

endmodule

// File: rtl/channel_playback.sv
// Replays buffered packed CH_H/CH_L pairs at a programmable sample rate.
module channel_playback
    import channel_pb_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WORD_W-1:0]         wdata,
    input  logic                      wrt,
    output logic                      rdy,
    input  logic                      run,
    input  logic [7:0]                rate,
    input  logic                      clr_err,
    output logic                      CH_H,
    output logic                      CH_L,
    output logic                      busy,
    output logic                      underrun,
    output logic                      overflow,
    output logic [$clog2(DEPTH):0]    cnt
);

    pb_state_t          state;
    logic [7:0]         presc;
    logic [7:0]         rate_q;
    pair_idx_t          idx;
    logic [WORD_W-1:0]  shreg;
    logic [WORD_W-1:0]  rdata;
    logic               full;
    logic               empty;
    logic               tick;
    logic               need_pop;
    logic               pop;
    logic               push;
    logic               und_set;
    logic               ovf_set;

    playback_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .cnt   (cnt)
    );

    // Tick, pop and error qualification; pop sees emptiness before any same-cycle push.
    always_comb begin
        tick     = (state == PLAY) && run && (presc == rate_q);
        need_pop = tick && (idx == 2'd0);
        pop      = need_pop && !empty;
        und_set  = need_pop && empty;
        push     = wrt && !full;
        ovf_set  = wrt && full;
    end

    assign rdy  = !full;
    assign busy = (state == PLAY);

    // Playback FSM, prescaler, shift register and channel output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            presc  <= 8'd0;
            rate_q <= 8'd0;
            idx    <= 2'd0;
            shreg  <= '0;
            CH_H   <= 1'b0;
            CH_L   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    presc  <= 8'd0;
                    rate_q <= rate;
                    if (run) state <= PLAY;
                end
                PLAY: begin
                    if (!run) begin
                        // Leaving play drops whatever is left of the current word.
                        state <= IDLE;
                        presc <= 8'd0;
                        idx   <= 2'd0;
                    end else if (tick) begin
                        presc  <= 8'd0;
                        rate_q <= rate;
                        if (idx == 2'd0) begin
                            if (!empty) begin
                                shreg <= rdata;
                                CH_H  <= rdata[1];
                                CH_L  <= rdata[0];
                                idx   <= 2'd1;
                            end
                        end else begin
                            CH_H <= shreg[{idx, 1'b1}];
                            CH_L <= shreg[{idx, 1'b0}];
                            idx  <= idx + 2'd1;
                        end
                    end else begin
                        presc <= presc + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (und_set)      underrun <= 1'b1;
            else if (clr_err) underrun <= 1'b0;
            if (ovf_set)      overflow <= 1'b1;
            else if (clr_err) overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_channel_playback.sv
// Directed plus randomized checks of channel_playback against a queue-based reference.
module tb_channel_playback;

    localparam int unsigned DEPTH = 8;

    logic       clk;
    logic       rst_n;
    logic [7:0] wdata;
    logic       wrt;
    logic       rdy;
    logic       run;
    logic [7:0] rate;
    logic       clr_err;
    logic       CH_H;
    logic       CH_L;
    logic       busy;
    logic       underrun;
    logic       overflow;
    logic [3:0] cnt;

    int checks   = 0;
    int failures = 0;

    // Reference state: words waiting, the word being played, how many pairs of it are out.
    logic [7:0] m_q[$];
    bit         m_play;
    int         m_ph;
    int         m_rate;
    int         m_pair;
    logic [7:0] m_word;
    logic [1:0] m_ch;
    bit         m_und;
    bit         m_ovf;

    channel_playback #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wdata    (wdata),
        .wrt      (wrt),
        .rdy      (rdy),
        .run      (run),
        .rate     (rate),
        .clr_err  (clr_err),
        .CH_H     (CH_H),
        .CH_L     (CH_L),
        .busy     (busy),
        .underrun (underrun),
        .overflow (overflow),
        .cnt      (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_play = 0;
        m_ph   = 0;
        m_rate = 0;
        m_pair = 0;
        m_word = 8'h00;
        m_ch   = 2'b00;
        m_und  = 0;
        m_ovf  = 0;
    endtask

    // Advance the reference by one clock using the inputs applied for that clock.
    task automatic model_step();
        bit was_full;
        bit was_empty;
        bit tick;
        bit new_und;
        bit new_ovf;
        was_full  = (m_q.size() == DEPTH);
        was_empty = (m_q.size() == 0);
        tick      = m_play && run && (m_ph == m_rate);
        new_und   = 0;
        new_ovf   = 0;
        if (tick) begin
            if (m_pair == 0) begin
                if (!was_empty) begin
                    m_word = m_q.pop_front();
                    m_ch   = m_word[1:0];
                    m_pair = 1;
                end else begin
                    new_und = 1;
                end
            end else begin
                m_ch   = 2'((m_word >> (2 * m_pair)) & 8'h03);
                m_pair = (m_pair + 1) % 4;
            end
        end
        if (wrt) begin
            if (was_full) new_ovf = 1;
            else          m_q.push_back(wdata);
        end
        m_und = new_und ? 1'b1 : (clr_err ? 1'b0 : m_und);
        m_ovf = new_ovf ? 1'b1 : (clr_err ? 1'b0 : m_ovf);
        if (!m_play) begin
            if (run) begin
                m_play = 1;
                m_ph   = 0;
                m_rate = int'(rate);
            end
        end else if (!run) begin
            m_play = 0;
            m_ph   = 0;
            m_pair = 0;
        end else if (tick) begin
            m_ph   = 0;
            m_rate = int'(rate);
        end else begin
            m_ph++;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".ch"},   {30'd0, CH_H, CH_L}, {30'd0, m_ch});
        check({tag, ".busy"}, 32'(busy),     32'(m_play));
        check({tag, ".cnt"},  32'(cnt),      32'(m_q.size()));
        check({tag, ".rdy"},  32'(rdy),      32'(m_q.size() != DEPTH));
        check({tag, ".und"},  32'(underrun), 32'(m_und));
        check({tag, ".ovf"},  32'(overflow), 32'(m_ovf));
    endtask

    task automatic cyc(input string tag, input bit w, input logic [7:0] d, input bit r, input bit c);
        @(negedge clk);
        wrt     = w;
        wdata   = d;
        run     = r;
        clr_err = c;
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    initial begin
        bit         reached;
        bit         run_s;
        logic [7:0] words[2];

        rst_n   = 1'b0;
        wrt     = 1'b0;
        wdata   = 8'h00;
        run     = 1'b0;
        rate    = 8'd0;
        clr_err = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        check("reset.rdy_const", 32'(rdy), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single word at rate 0: four pairs on consecutive clocks, then underrun.
        cyc("s1.push", 1, 8'hE4, 0, 0);
        cyc("s1.start", 0, 8'h00, 1, 0);
        check("s1.busy", 32'(busy), 32'd1);
        cyc("s1.p0", 0, 8'h00, 1, 0);
        check("s1.p0v", {30'd0, CH_H, CH_L}, 32'd0);
        cyc("s1.p1", 0, 8'h00, 1, 0);
        check("s1.p1v", {30'd0, CH_H, CH_L}, 32'd1);
        cyc("s1.p2", 0, 8'h00, 1, 0);
        check("s1.p2v", {30'd0, CH_H, CH_L}, 32'd2);
        cyc("s1.p3", 0, 8'h00, 1, 0);
        check("s1.p3v", {30'd0, CH_H, CH_L}, 32'd3);
        cyc("s1.und", 0, 8'h00, 1, 0);
        check("s1.undv", 32'(underrun), 32'd1);
        check("s1.hold", {30'd0, CH_H, CH_L}, 32'd3);
        cyc("s1.stop", 0, 8'h00, 0, 0);
        cyc("s1.clr", 0, 8'h00, 0, 1);
        check("s1.clrv", {30'd0, underrun, overflow}, 32'd0);

        // Two words at rate 3: each pair held four clocks.
        rate = 8'd3;
        cyc("s2.push0", 1, 8'h1B, 0, 0);
        cyc("s2.push1", 1, 8'hC6, 0, 0);
        for (int i = 0; i < 36; i++) cyc("s2.play", 0, 8'h00, 1, 0);
        cyc("s2.stop", 0, 8'h00, 0, 1);

        // Nine pushes while idle: full, overflow, ninth word dropped.
        for (int i = 0; i < 9; i++) cyc("s3.push", 1, 8'(8'h10 + i * 8'h1D), 0, 0);
        check("s3.cnt", 32'(cnt), 32'd8);
        check("s3.rdy", 32'(rdy), 32'd0);
        check("s3.ovf", 32'(overflow), 32'd1);
        rate = 8'd0;
        for (int i = 0; i < 40; i++) cyc("s3.drain", 0, 8'h00, 1, 0);
        cyc("s3.stop", 0, 8'h00, 0, 1);

        // Empty FIFO at rate 0: push lands on a pop tick, underruns, then plays next tick.
        cyc("s4.start", 0, 8'h00, 1, 0);
        cyc("s4.und0", 0, 8'h00, 1, 0);
        cyc("s4.pushtick", 1, 8'h93, 1, 1);
        check("s4.undwins", 32'(underrun), 32'd1);
        check("s4.cnt", 32'(cnt), 32'd1);
        cyc("s4.play", 0, 8'h00, 1, 0);
        check("s4.pair0", {30'd0, CH_H, CH_L}, 32'd3);
        for (int i = 0; i < 4; i++) cyc("s4.tail", 0, 8'h00, 1, 0);
        cyc("s4.stop", 0, 8'h00, 0, 1);

        // Mid-word stop and restart at rate 3.
        rate = 8'd3;
        words[0] = 8'(($urandom & 8'hFC) | 8'h01);
        words[1] = 8'(($urandom & 8'hFC) | 8'h02);
        cyc("s5.push0", 1, words[0], 0, 0);
        cyc("s5.push1", 1, words[1], 0, 0);
        reached = 0;
        for (int i = 0; i < 40 && !reached; i++) begin
            cyc("s5.play", 0, 8'h00, 1, 0);
            reached = (m_pair == 2) && (m_ph == 1);
        end
        check("s5.reach", 32'(reached), 32'd1);
        cyc("s5.drop", 0, 8'h00, 0, 0);
        check("s5.busy", 32'(busy), 32'd0);
        for (int i = 0; i < 6; i++) cyc("s5.resume", 0, 8'h00, 1, 0);
        check("s5.nextword", {30'd0, CH_H, CH_L}, {30'd0, words[1][1:0]});
        for (int i = 0; i < 12; i++) cyc("s5.tail", 0, 8'h00, 1, 0);
        cyc("s5.stop", 0, 8'h00, 0, 1);

        // Randomized traffic, rate changes, run toggles and clears.
        run_s = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) rate = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 24) == 0) begin
                if (!run_s) run_s = 1;
                else if (!(m_play && m_ph == m_rate)) run_s = 0;
            end
            cyc("rnd", $urandom_range(0, 3) == 0, 8'($urandom), run_s, $urandom_range(0, 19) == 0);
        end

        // Asynchronous reset in the middle of playback with flags set.
        rate = 8'd1;
        for (int i = 0; i < 9; i++) cyc("s7.fill", 1, 8'($urandom), 0, 0);
        for (int i = 0; i < 5; i++) cyc("s7.play", 0, 8'h00, 1, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("s7.ch", {30'd0, CH_H, CH_L}, 32'd0);
        check("s7.cnt", 32'(cnt), 32'd0);
        check("s7.flags", {30'd0, underrun, overflow}, 32'd0);
        check("s7.busy", 32'(busy), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc("s7.after", 0, 8'h00, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/channel_playback.md
# channel_playback

Stimulus-side counterpart of the analyzer's channel sampler. It accepts packed 8-bit sample words, each holding four CH_H/CH_L pairs in the sampler's packing order with the oldest pair in bits [1:0]. It buffers the words in a small FIFO and replays the pairs onto CH_H/CH_L at a programmable sample rate. It drives the analog-front-end stand-in during self-test and loopback capture.

## Interface
- DEPTH, 8: FIFO depth in words; must be a power of 2, at least 2.
- clk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous reset, active-low.
- wdata  in  8  packed word {H3,L3,H2,L2,H1,L1,H0,L0}; pair 0 is the oldest and is played first.
- wrt  in  1  push strobe; sampled every clk.
- rdy  out  1  FIFO not full; combinational from the registered count.
- run  in  1  level; playback enabled while high.
- rate  in  8  clocks per sample minus 1; sampled at each tick.
- clr_err  in  1  one-cycle pulse; clears underrun and overflow.
- CH_H, CH_L  out  1 each  replayed channel levels, driven straight from flops.
- busy  out  1  high when in state PLAY.
- underrun  out  1  sticky; a word was needed while the FIFO was empty.
- overflow  out  1  sticky; a push arrived while the FIFO was full.
- cnt  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Reset values: CH_H=0, CH_L=0, busy=0, underrun=0, overflow=0, cnt=0, rdy=1. Prescaler, pair index and shift register are all 0.
- Push: when wrt=1 and cnt<DEPTH, wdata is written and cnt increments.
  - A push while full is dropped and sets overflow. This holds even if a pop happens in the same cycle.
- States:
  - IDLE: prescaler is held at 0. Outputs hold their last values.
  - IDLE -> PLAY when run=1.
  - PLAY -> IDLE when run=0. The move takes effect the next cycle and discards the partial word.
- Prescaler in PLAY: counts 0..rate. A tick is the cycle where prescaler==rate, after which the prescaler returns to 0.
- On a tick with idx==0:
  - FIFO not empty: pop the word into the shift register, drive {CH_H,CH_L}=word[1:0], set idx=1.
  - FIFO empty: set underrun, leave the outputs unchanged, keep idx=0. The next tick retries.
- On a tick with idx!=0: drive the pair at shreg[2*idx+1 : 2*idx], then idx=idx+1 modulo 4.
- Simultaneous push and pop:
  - cnt is unchanged when both succeed.
  - A push into an empty FIFO in the same cycle as a tick needing a pop does not satisfy that pop. The tick underruns and the word is kept.
- clr_err in the same cycle as a new error: the error wins and the flag stays set.
- Reset asserted mid-play: everything returns to its reset values immediately, regardless of clk.

## Timing
- run rises at edge N. The first tick is at edge N+1+rate, and the CH outputs change at that edge.
- Pair period is rate+1 clocks. One word lasts 4*(rate+1) clocks.
- Push-to-visible latency: a word written at edge k can be popped at edge k+1 or later.
- rate=0: a pair every clock. A sustained stream needs one push every 4 clocks.
- rate changes take effect after the current tick completes.
- Flags update on the edge of the offending event and are visible the next cycle.

## Structure
- Package channel_pb_pkg holds:
  - typedef enum logic {IDLE, PLAY} pb_state_t;
  - typedef logic [1:0] pair_idx_t;
  - localparam PAIRS_PER_WORD = 4.
- Sub-module playback_fifo (parameter DEPTH): circular buffer with separate read and write pointers one bit wider than the address, and synchronous write.
  - Read is combinational from the read pointer.
  - It exports full, empty and cnt.
- Top level: FSM, prescaler, shift register/index and output flops.

## Test plan
- Reset, then push 8'hE4, then run=1 with rate=0:
  - {H,L} = 00, 01, 10, 11 on four consecutive clocks.
  - busy=1.
  - underrun sets on the fifth tick; outputs hold 11.
- rate=3 with two words pushed: each pair is held exactly 4 clocks; cnt goes 2→1→0 at the pops.
- Push 9 words while run=0 (DEPTH=8):
  - cnt=8, rdy=0, overflow=1.
  - The 9th word is never played.
- rate=0 with the FIFO empty: push on the same clock as a pop tick. Underrun sets, then the word plays on the next tick.
- Mid-word:
  - Drop run after 2 pairs: busy=0 next cycle.
  - Raise run again: playback restarts at pair 0 of the next FIFO word.
- Assert rst_n=0 asynchronously mid-play: CH_H=CH_L=0, cnt=0 and flags=0 before the next clk edge.
- clr_err pulse with no concurrent error: both flags clear.
